boot_loader: RTL and testbench

Sequencer that owns the instruction and data BRAM write ports of the rv32i core during boot. It accepts a word stream over a valid/ready handshake, writes the data image into data BRAM and then the program into instruction BRAM. It then hands data-BRAM control to the datapath (`d_bram_init_done`) and releases the PC, register-file read and instruction-fetch enables. It replaces manual load sequencing and sits between the host/UART front end and the `bram32` instances.

---
 rtl/boot_loader_pkg.sv | 17 +
 rtl/boot_loader_if.sv | 9 +
 rtl/boot_word_counter.sv | 35 +++
 rtl/boot_loader.sv | 190 +++++++++++++++++++
 tb/tb_boot_loader.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and defaults for the boot loader: state encoding and default widths.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_DATA  = 3'd1,
    ST_LOAD_INSTR = 3'd2,
    ST_SETTLE     = 3'd3,
    ST_RUN        = 3'd4,
    ST_ERROR      = 3'd5,
    ST_CHECK      = 3'd6
  } boot_state_e;

  localparam int BOOT_ADDR_WIDTH = 10;
  localparam int BOOT_DATA_WIDTH = 32;

endpackage

// File: rtl/boot_loader_if.sv
// Valid/ready word stream from the host/UART front end into the boot loader.
interface boot_loader_if #(parameter int DATA_WIDTH = 32);
  logic                  s_valid;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/boot_word_counter.sv
// Word index counter shared by both load phases; cleared on each phase entry,
// flags the last word of the phase and presents the matching byte address.
module boot_word_counter #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  inc_i,
  input  logic [ADDR_WIDTH-2:0] limit_i,
  output logic                  tc_o,
  output logic [ADDR_WIDTH-1:0] addr_o
);

  localparam logic [ADDR_WIDTH-3:0] CNT_ONE   = {{(ADDR_WIDTH-3){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-2:0] LIMIT_ONE = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // limit of 0 wraps to all-ones and never matches; zero-length phases are skipped upstream
  assign tc_o   = ({1'b0, cnt_q} == (limit_i - LIMIT_ONE));
  assign addr_o = {cnt_q, 2'b00};

endmodule

// File: rtl/boot_loader.sv
// Boot sequencer: streams the data image then the program into BRAM and releases the core.
// Optional BOOT_LOADER_CHECKSUM_EN adds a trailing checksum beat (CHECK state).
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = BOOT_ADDR_WIDTH,
  parameter int DATA_WIDTH = BOOT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-2:0] d_count_i,
  input  logic [ADDR_WIDTH-2:0] i_count_i,
  input  logic                  halt_i,
  boot_loader_if.slave          s_if,
  output logic [ADDR_WIDTH-1:0] d_w_addr_o,
  output logic [DATA_WIDTH-1:0] d_w_dat_o,
  output logic                  d_w_enb_o,
  output logic [ADDR_WIDTH-1:0] i_w_addr_o,
  output logic [DATA_WIDTH-1:0] i_w_dat_o,
  output logic                  i_w_enb_o,
  output logic                  d_bram_init_done_o,
  output logic                  pc_stall_o,
  output logic                  rd_enbl_o,
  output logic                  i_r_enb_o,
  output logic                  busy_o,
  output logic                  error_o
);

  localparam int CW = ADDR_WIDTH - 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** (ADDR_WIDTH - 2));

`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam boot_state_e ST_END = ST_CHECK;
`else
  localparam boot_state_e ST_END = ST_SETTLE;
`endif

  boot_state_e           state_q, state_d;
  logic [CW-1:0]         d_cnt_q, d_cnt_d, i_cnt_q, i_cnt_d;
  logic                  error_q, error_d;
  logic                  s_ready_q, busy_q, init_done_q, run_q, pc_stall_q;
  logic                  d_we_q, i_we_q, d_we_d, i_we_d;
  logic [ADDR_WIDTH-1:0] d_addr_q, i_addr_q, word_addr;
  logic [DATA_WIDTH-1:0] d_dat_q, i_dat_q;
  logic                  accept, counts_bad, cnt_clr, cnt_tc;
  logic [CW-1:0]         cnt_limit;

  assign accept     = s_if.s_valid && s_ready_q;
  assign counts_bad = (d_count_i > DEPTH) || (i_count_i > DEPTH);
  assign cnt_limit  = (state_q == ST_LOAD_INSTR) ? i_cnt_q : d_cnt_q;

  boot_word_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (cnt_clr),
    .inc_i   (accept),
    .limit_i (cnt_limit),
    .tc_o    (cnt_tc),
    .addr_o  (word_addr)
  );

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  always_comb begin
    state_d = state_q;
    d_cnt_d = d_cnt_q;
    i_cnt_d = i_cnt_q;
    error_d = error_q;
    cnt_clr = 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
    sum_d = sum_q;
    if (accept && (state_q == ST_LOAD_DATA || state_q == ST_LOAD_INSTR))
      sum_d = sum_q + s_if.s_data;
`endif
    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start_i) begin
          error_d = counts_bad;
          d_cnt_d = d_count_i;
          i_cnt_d = i_count_i;
          cnt_clr = 1'b1;
`ifdef BOOT_LOADER_CHECKSUM_EN
          sum_d = '0;
`endif
          if (counts_bad)          state_d = ST_ERROR;
          else if (d_count_i != 0) state_d = ST_LOAD_DATA;
          else if (i_count_i != 0) state_d = ST_LOAD_INSTR;
          else                     state_d = ST_END;
        end
      end
      ST_LOAD_DATA: begin
        if (accept && cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = (i_cnt_q != 0) ? ST_LOAD_INSTR : ST_END;
        end
      end
      ST_LOAD_INSTR: begin
        if (accept && cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = ST_END;
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) begin
          if (s_if.s_data == sum_q) state_d = ST_SETTLE;
          else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
`endif
      ST_SETTLE: state_d = ST_RUN;
      ST_RUN:    if (halt_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign d_we_d = accept && (state_q == ST_LOAD_DATA);
  assign i_we_d = accept && (state_q == ST_LOAD_INSTR);

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      d_cnt_q     <= '0;
      i_cnt_q     <= '0;
      error_q     <= 1'b0;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      init_done_q <= 1'b0;
      run_q       <= 1'b0;
      pc_stall_q  <= 1'b1;
      d_we_q      <= 1'b0;
      i_we_q      <= 1'b0;
      d_addr_q    <= '0;
      i_addr_q    <= '0;
      d_dat_q     <= '0;
      i_dat_q     <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      d_cnt_q     <= d_cnt_d;
      i_cnt_q     <= i_cnt_d;
      error_q     <= error_d;
      s_ready_q   <= (state_d == ST_LOAD_DATA) || (state_d == ST_LOAD_INSTR) ||
                     (state_d == ST_CHECK);
      busy_q      <= (state_d == ST_LOAD_DATA) || (state_d == ST_LOAD_INSTR) ||
                     (state_d == ST_SETTLE) || (state_d == ST_CHECK);
      init_done_q <= (state_d == ST_LOAD_INSTR) || (state_d == ST_SETTLE) ||
                     (state_d == ST_RUN) || (state_d == ST_CHECK);
      run_q       <= (state_d == ST_RUN);
      pc_stall_q  <= (state_d != ST_RUN);
      d_we_q      <= d_we_d;
      i_we_q      <= i_we_d;
      if (d_we_d) begin
        d_addr_q <= word_addr;
        d_dat_q  <= s_if.s_data;
      end
      if (i_we_d) begin
        i_addr_q <= word_addr;
        i_dat_q  <= s_if.s_data;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign s_if.s_ready       = s_ready_q;
  assign d_w_addr_o         = d_addr_q;
  assign d_w_dat_o          = d_dat_q;
  assign d_w_enb_o          = d_we_q;
  assign i_w_addr_o         = i_addr_q;
  assign i_w_dat_o          = i_dat_q;
  assign i_w_enb_o          = i_we_q;
  assign d_bram_init_done_o = init_done_q;
  assign pc_stall_o         = pc_stall_q;
  assign rd_enbl_o          = run_q;
  assign i_r_enb_o          = run_q;
  assign busy_o             = busy_q;
  assign error_o            = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: load sequences, stream gaps, reset abort, count errors.
module tb_boot_loader;

  localparam logic [31:0] DBASE = 32'hD000_0000;
  localparam logic [31:0] IBASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic [8:0]  d_count = '0;
  logic [8:0]  i_count = '0;
  logic [9:0]  d_w_addr, i_w_addr;
  logic [31:0] d_w_dat, i_w_dat;
  logic        d_w_enb, i_w_enb, init_done, pc_stall, rd_enbl, i_r_enb, busy, error;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [9:0]  d_addr_log[$], i_addr_log[$];
  logic [31:0] d_dat_log[$], i_dat_log[$];
  int          d_cyc_log[$], i_cyc_log[$];

  boot_loader_if #(.DATA_WIDTH(32)) s_if ();

  boot_loader dut (
    .clk                (clk),
    .rst                (rst),
    .start_i            (start),
    .d_count_i          (d_count),
    .i_count_i          (i_count),
    .halt_i             (halt),
    .s_if               (s_if),
    .d_w_addr_o         (d_w_addr),
    .d_w_dat_o          (d_w_dat),
    .d_w_enb_o          (d_w_enb),
    .i_w_addr_o         (i_w_addr),
    .i_w_dat_o          (i_w_dat),
    .i_w_enb_o          (i_w_enb),
    .d_bram_init_done_o (init_done),
    .pc_stall_o         (pc_stall),
    .rd_enbl_o          (rd_enbl),
    .i_r_enb_o          (i_r_enb),
    .busy_o             (busy),
    .error_o            (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (d_w_enb === 1'b1) begin
      d_addr_log.push_back(d_w_addr);
      d_dat_log.push_back(d_w_dat);
      d_cyc_log.push_back(cyc);
    end
    if (i_w_enb === 1'b1) begin
      i_addr_log.push_back(i_w_addr);
      i_dat_log.push_back(i_w_dat);
      i_cyc_log.push_back(cyc);
    end
  end

  task automatic clear_logs();
    d_addr_log.delete(); d_dat_log.delete(); d_cyc_log.delete();
    i_addr_log.delete(); i_dat_log.delete(); i_cyc_log.delete();
  endtask

  task automatic drive_start(input int d, input int i);
    @(posedge clk); #1;
    start = 1'b1; d_count = d[8:0]; i_count = i[8:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [31:0] base, input bit gaps);
    for (int k = 0; k < n; k++) begin
      if (gaps) begin
        s_if.s_valid = 1'b0; s_if.s_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        total++;
        if (s_if.s_ready !== 1'b1) begin
          bad++; $display("FAIL gap_ready k=%0d got=%b exp=1", k, s_if.s_ready);
        end
      end
      s_if.s_valid = 1'b1; s_if.s_data = base + 32'(k);
      @(posedge clk); #1;
    end
    s_if.s_valid = 1'b0;
  endtask

  task automatic send_checksum(input int d, input int i, input logic [31:0] delta);
`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [31:0] sum = delta;
    for (int k = 0; k < d; k++) sum = sum + DBASE + 32'(k);
    for (int k = 0; k < i; k++) sum = sum + IBASE + 32'(k);
    s_if.s_valid = 1'b1; s_if.s_data = sum;
    @(posedge clk); #1;
    s_if.s_valid = 1'b0;
`endif
  endtask

  task automatic run_load(input int d, input int i, input bit gaps);
    drive_start(d, i);
    send_words(d, DBASE, gaps);
    send_words(i, IBASE, gaps);
    send_checksum(d, i, 32'd0);
  endtask

  task automatic do_halt(input string tag);
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    total++;
    if (pc_stall !== 1'b1 || init_done !== 1'b0 || rd_enbl !== 1'b0) begin
      bad++; $display("FAIL %s_halt got pc_stall=%b done=%b rd=%b exp 1/0/0", tag, pc_stall, init_done, rd_enbl);
    end
  endtask

  task automatic test_reset();
    total++;
    if (pc_stall !== 1'b1 || s_if.s_ready !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got pc_stall=%b rdy=%b busy=%b err=%b exp 1/0/0/0", pc_stall, s_if.s_ready, busy, error);
    end
    total++;
    if (d_w_enb !== 1'b0 || i_w_enb !== 1'b0 || rd_enbl !== 1'b0 || i_r_enb !== 1'b0 || init_done !== 1'b0) begin
      bad++; $display("FAIL reset_enables got d=%b i=%b rd=%b ir=%b done=%b exp 0", d_w_enb, i_w_enb, rd_enbl, i_r_enb, init_done);
    end
    total++;
    if (d_w_addr !== 10'h0 || i_w_addr !== 10'h0 || d_w_dat !== 32'h0 || i_w_dat !== 32'h0) begin
      bad++; $display("FAIL reset_bus got da=%h ia=%h dd=%h id=%h exp 0", d_w_addr, i_w_addr, d_w_dat, i_w_dat);
    end
  endtask

  task automatic check_logs(input string tag, input int d, input int i, input int spacing);
    total++;
    if (d_addr_log.size() != d || i_addr_log.size() != i) begin
      bad++; $display("FAIL %s_count got d=%0d i=%0d exp d=%0d i=%0d", tag, d_addr_log.size(), i_addr_log.size(), d, i);
    end else begin
      for (int k = 0; k < d; k++) begin
        total++;
        if (d_addr_log[k] !== 10'(k * 4) || d_dat_log[k] !== DBASE + 32'(k) || d_cyc_log[k] != d_cyc_log[0] + k * spacing) begin
          bad++; $display("FAIL %s_dwr k=%0d got a=%h d=%h c=%0d exp a=%h d=%h c=%0d", tag, k, d_addr_log[k], d_dat_log[k], d_cyc_log[k], 10'(k * 4), DBASE + 32'(k), d_cyc_log[0] + k * spacing);
        end
      end
      for (int k = 0; k < i; k++) begin
        total++;
        if (i_addr_log[k] !== 10'(k * 4) || i_dat_log[k] !== IBASE + 32'(k) || i_cyc_log[k] != i_cyc_log[0] + k * spacing) begin
          bad++; $display("FAIL %s_iwr k=%0d got a=%h d=%h c=%0d exp a=%h d=%h c=%0d", tag, k, i_addr_log[k], i_dat_log[k], i_cyc_log[k], 10'(k * 4), IBASE + 32'(k), i_cyc_log[0] + k * spacing);
        end
      end
      if (d > 0 && i > 0) begin
        total++;
        if (i_cyc_log[0] != d_cyc_log[d-1] + spacing) begin
          bad++; $display("FAIL %s_phase_gap got=%0d exp=%0d", tag, i_cyc_log[0] - d_cyc_log[d-1], spacing);
        end
      end
    end
  endtask

  task automatic check_settle_run(input string tag);
    total++;
    if (busy !== 1'b1 || pc_stall !== 1'b1 || s_if.s_ready !== 1'b0) begin
      bad++; $display("FAIL %s_settle got busy=%b pc_stall=%b rdy=%b exp 1/1/0", tag, busy, pc_stall, s_if.s_ready);
    end
    @(posedge clk); #1;
    total++;
    if (pc_stall !== 1'b0 || rd_enbl !== 1'b1 || i_r_enb !== 1'b1 || busy !== 1'b0 || init_done !== 1'b1) begin
      bad++; $display("FAIL %s_run got pc_stall=%b rd=%b ir=%b busy=%b done=%b exp 0/1/1/0/1", tag, pc_stall, rd_enbl, i_r_enb, busy, init_done);
    end
  endtask

  task automatic test_continuous();
    clear_logs();
    run_load(10, 3, 1'b0);
    check_settle_run("cont");
    check_logs("cont", 10, 3, 1);
    drive_start(1, 1);
    total++;
    if (pc_stall !== 1'b0 || busy !== 1'b0 || s_if.s_ready !== 1'b0) begin
      bad++; $display("FAIL run_start_ignored got pc_stall=%b busy=%b rdy=%b exp 0/0/0", pc_stall, busy, s_if.s_ready);
    end
    do_halt("cont");
  endtask

  task automatic test_gapped();
    clear_logs();
    run_load(10, 3, 1'b1);
    check_settle_run("gap");
    check_logs("gap", 10, 3, 2);
    do_halt("gap");
  endtask

  task automatic test_zero_data();
    clear_logs();
    drive_start(0, 3);
    total++;
    if (init_done !== 1'b1 || s_if.s_ready !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL zd_entry got done=%b rdy=%b busy=%b exp 1/1/1", init_done, s_if.s_ready, busy);
    end
    send_words(3, IBASE, 1'b0);
    send_checksum(0, 3, 32'd0);
    check_settle_run("zd");
    check_logs("zd", 0, 3, 1);
    do_halt("zd");
  endtask

  task automatic test_boundary();
    clear_logs();
    drive_start(0, 0);
    send_checksum(0, 0, 32'd0);
    check_settle_run("zero");
    do_halt("zero");
    run_load(0, 256, 1'b0);
    total++;
    if (error !== 1'b0) begin
      bad++; $display("FAIL full_depth_err got=%b exp=0", error);
    end
    check_settle_run("full");
    check_logs("full", 0, 256, 1);
    do_halt("full");
  endtask

  task automatic test_reset_mid_load();
    clear_logs();
    drive_start(10, 3);
    send_words(5, DBASE, 1'b0);
    s_if.s_valid = 1'b1; s_if.s_data = DBASE + 32'd5;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (pc_stall !== 1'b1 || s_if.s_ready !== 1'b0 || busy !== 1'b0 || d_w_enb !== 1'b0 || init_done !== 1'b0) begin
      bad++; $display("FAIL rstmid_state got pc_stall=%b rdy=%b busy=%b we=%b done=%b exp 1/0/0/0/0", pc_stall, s_if.s_ready, busy, d_w_enb, init_done);
    end
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    s_if.s_valid = 1'b0;
    check_logs("rstmid", 5, 0, 1);
  endtask

  task automatic test_count_error();
    clear_logs();
    drive_start(2, 257);
    s_if.s_valid = 1'b1; s_if.s_data = 32'h5555_AAAA;
    total++;
    if (error !== 1'b1 || s_if.s_ready !== 1'b0 || pc_stall !== 1'b1 || busy !== 1'b0 || init_done !== 1'b0) begin
      bad++; $display("FAIL err_state got err=%b rdy=%b pc_stall=%b busy=%b done=%b exp 1/0/1/0/0", error, s_if.s_ready, pc_stall, busy, init_done);
    end
    repeat (3) begin @(posedge clk); #1; end
    s_if.s_valid = 1'b0;
    total++;
    if (error !== 1'b1 || d_addr_log.size() != 0 || i_addr_log.size() != 0) begin
      bad++; $display("FAIL err_sticky got err=%b dw=%0d iw=%0d exp 1/0/0", error, d_addr_log.size(), i_addr_log.size());
    end
    drive_start(2, 1);
    total++;
    if (error !== 1'b0 || s_if.s_ready !== 1'b1) begin
      bad++; $display("FAIL err_retry got err=%b rdy=%b exp 0/1", error, s_if.s_ready);
    end
    send_words(2, DBASE, 1'b0);
    send_words(1, IBASE, 1'b0);
    send_checksum(2, 1, 32'd0);
    check_settle_run("retry");
    check_logs("retry", 2, 1, 1);
    do_halt("retry");
  endtask

`ifdef BOOT_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    drive_start(2, 1);
    send_words(2, DBASE, 1'b0);
    send_words(1, IBASE, 1'b0);
    send_checksum(2, 1, 32'd1);
    total++;
    if (error !== 1'b1 || pc_stall !== 1'b1 || busy !== 1'b0 || s_if.s_ready !== 1'b0) begin
      bad++; $display("FAIL cksum_bad got err=%b pc_stall=%b busy=%b rdy=%b exp 1/1/0/0", error, pc_stall, busy, s_if.s_ready);
    end
    @(posedge clk); #1;
    total++;
    if (pc_stall !== 1'b1) begin
      bad++; $display("FAIL cksum_stall got=%b exp=1", pc_stall);
    end
  endtask
`endif

  initial begin
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    test_continuous();
    test_gapped();
    test_zero_data();
    test_boundary();
    test_reset_mid_load();
    test_count_error();
`ifdef BOOT_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
